// File: rtl/piso_tx.sv
// Framed parallel-in serial-out transmitter: start bit, WIDTH data bits LSB first, stop bit(s).
// Bit rate is set by CLKS_PER_BIT; the line idles high.
module piso_tx #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             tx_done
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BIT_MAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
    localparam int unsigned BIT_W   = $clog2(BIT_MAX) + 1;

    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] cyc_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             bit_end;
    logic [WIDTH-1:0] shift_next;

    assign in_ready   = (state == IDLE);
    assign bit_end    = (cyc_cnt == CYC_LAST);
    assign shift_next = shift_reg >> 1;

    // Frame sequencer; serial_out is loaded with the level of the bit that begins next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift_reg  <= in_data;
                        state      <= START;
                        serial_out <= 1'b0;
                        busy       <= 1'b1;
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt    <= '0;
                        state      <= DATA;
                        serial_out <= shift_reg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt   <= '0;
                        shift_reg <= shift_next;
                        if (bit_cnt == DATA_LAST) begin
                            state      <= STOP;
                            bit_cnt    <= '0;
                            serial_out <= 1'b1;
                        end else begin
                            bit_cnt    <= bit_cnt + BIT_W'(1);
                            serial_out <= shift_next[0];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (1 and 4 clocks per bit) checked cycle by cycle
// against an expected-waveform queue built from the frame format.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d1_data, d4_data;
    logic       d1_valid, d4_valid;
    logic       d1_ready, d4_ready;
    logic       d1_ser, d4_ser;
    logic       d1_busy, d4_busy;
    logic       d1_done, d4_done;

    int vectors = 0;
    int miscompares = 0;
    int done_seen;
    int done_exp;

    bit exp_ser[$];
    bit exp_busy[$];
    bit exp_done[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(d1_data), .in_valid(d1_valid),
        .in_ready(d1_ready), .serial_out(d1_ser), .busy(d1_busy), .tx_done(d1_done)
    );

    piso_tx #(.WIDTH(4), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut4 (
        .clk(clk), .reset(reset), .in_data(d4_data), .in_valid(d4_valid),
        .in_ready(d4_ready), .serial_out(d4_ser), .busy(d4_busy), .tx_done(d4_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ser(input int sel);
        return (sel != 0) ? d4_ser : d1_ser;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel != 0) ? d4_busy : d1_busy;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel != 0) ? d4_done : d1_done;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel != 0) ? d4_ready : d1_ready;
    endfunction

    task automatic set_data(input int sel, input logic [3:0] data);
        if (sel != 0) d4_data = data; else d1_data = data;
    endtask
    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) d4_valid = v; else d1_valid = v;
    endtask

    // Expected line waveform: start 0, data LSB first, stop 1, each held cpb cycles, then a done cycle.
    task automatic append_frame(input logic [3:0] data, input int cpb);
        logic lvl;
        for (int p = 0; p < 6; p++) begin
            if (p == 0)      lvl = 1'b0;
            else if (p <= 4) lvl = data[p-1];
            else             lvl = 1'b1;
            for (int c = 0; c < cpb; c++) begin
                exp_ser.push_back(lvl);
                exp_busy.push_back(1'b1);
                exp_done.push_back(1'b0);
            end
        end
        exp_ser.push_back(1'b1);
        exp_busy.push_back(1'b0);
        exp_done.push_back(1'b1);
        done_exp++;
    endtask

    task automatic check_cycle(input int sel);
        bit es, eb, ed;
        @(negedge clk);
        es = exp_ser.pop_front();
        eb = exp_busy.pop_front();
        ed = exp_done.pop_front();
        chk("serial_out", 32'(get_ser(sel)), 32'(es));
        chk("busy", 32'(get_busy(sel)), 32'(eb));
        chk("tx_done", 32'(get_done(sel)), 32'(ed));
        chk("in_ready", 32'(get_ready(sel)), 32'(!eb));
        if (get_done(sel) === 1'b1) done_seen++;
    endtask

    task automatic start(input int sel, input logic [3:0] data);
        @(negedge clk);
        chk("ready_before_accept", 32'(get_ready(sel)), 32'd1);
        set_data(sel, data);
        set_valid(sel, 1'b1);
        done_seen = 0;
        done_exp  = 0;
    endtask

    // Walks the expected queue; optional in_data change, valid drop and mid-frame poke by cycle index.
    task automatic run_check(input int sel, input int drop_idx, input int chg_idx,
                             input logic [3:0] chg_data, input int poke_idx);
        int n;
        n = exp_ser.size();
        for (int i = 0; i < n; i++) begin
            check_cycle(sel);
            if (i == chg_idx) set_data(sel, chg_data);
            if (poke_idx >= 0 && i == poke_idx) begin
                set_data(sel, 4'hF);
                set_valid(sel, 1'b1);
            end
            if (poke_idx >= 0 && i == poke_idx + 1) set_valid(sel, 1'b0);
            if (i == drop_idx) set_valid(sel, 1'b0);
        end
        @(negedge clk);
        chk("tx_done_single", 32'(get_done(sel)), 32'd0);
        chk("serial_idle", 32'(get_ser(sel)), 32'd1);
        chk("tx_done_count", 32'(done_seen), 32'(done_exp));
    endtask

    initial begin
        logic [3:0] w0, w1;
        int sel, cpb, flen;

        reset = 1'b1;
        d1_data = 4'h9; d4_data = 4'h6;
        d1_valid = 1'b1; d4_valid = 1'b1;

        // Reset held 10 cycles with in_valid high: outputs stay at reset values.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                chk("rst_serial", 32'(get_ser(s)), 32'd1);
                chk("rst_ready", 32'(get_ready(s)), 32'd1);
                chk("rst_busy", 32'(get_busy(s)), 32'd0);
                chk("rst_done", 32'(get_done(s)), 32'd0);
            end
        end
        d1_valid = 1'b0; d4_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Directed frame 4'b1011 at one clock per bit.
        start(0, 4'b1011);
        append_frame(4'b1011, 1);
        run_check(0, 0, -1, 4'h0, -1);

        // 4'hA at four clocks per bit.
        start(1, 4'hA);
        append_frame(4'hA, 4);
        run_check(1, 0, -1, 4'h0, -1);

        // Back-to-back 4'h5 then 4'h3 with in_valid held high.
        start(0, 4'h5);
        append_frame(4'h5, 1);
        append_frame(4'h3, 1);
        run_check(0, 7, 0, 4'h3, -1);

        // Mid-frame in_data change and in_valid pulse must not disturb the frame.
        start(0, 4'h2);
        append_frame(4'h2, 1);
        run_check(0, 0, -1, 4'h0, 2);

        // Reset during data bit 2 aborts the frame immediately.
        start(0, 4'hC);
        append_frame(4'hC, 1);
        for (int i = 0; i < 4; i++) begin
            check_cycle(0);
            if (i == 0) d1_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("abort_serial", 32'(d1_ser), 32'd1);
        chk("abort_busy", 32'(d1_busy), 32'd0);
        chk("abort_done", 32'(d1_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(d1_done), 32'd0);
            chk("abort_idle", 32'(d1_ser), 32'd1);
        end
        exp_ser.delete(); exp_busy.delete(); exp_done.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("post_abort_no_done", 32'(d1_done), 32'd0);

        start(0, 4'h6);
        append_frame(4'h6, 1);
        run_check(0, 0, -1, 4'h0, -1);

        // Randomized single and back-to-back frames on both rates.
        for (int k = 0; k < 16; k++) begin
            sel  = int'($urandom_range(0, 1));
            cpb  = (sel != 0) ? 4 : 1;
            flen = 6 * cpb;
            w0   = 4'($urandom);
            w1   = 4'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                @(negedge clk);
                chk("gap_idle", 32'(get_ser(sel)), 32'd1);
                chk("gap_busy", 32'(get_busy(sel)), 32'd0);
            end
            start(sel, w0);
            append_frame(w0, cpb);
            if ($urandom_range(0, 1) == 1) begin
                append_frame(w1, cpb);
                run_check(sel, flen + 1, 0, w1, -1);
            end else begin
                run_check(sel, 0, -1, 4'h0, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
